// File: rtl/ysyx_22040088_ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040088_ifu_pkg
// Description : Shared types and constants for the NPC instruction fetch unit
//               (FSM encoding, sel_nextpc bit indices, default boot address).
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22040088_ifu_pkg;

  // Fetch FSM state encoding
  typedef enum logic [2:0] {
    S_BOOT      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_RESP = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_EX   = 3'd4,
    S_ERR       = 3'd5
  } ifu_state_t;

  // Bit positions inside the one-hot sel_nextpc bus (shared with controlunit)
  localparam int unsigned c_sel_seq  = 0;
  localparam int unsigned c_sel_jal  = 1;
  localparam int unsigned c_sel_jalr = 2;

  // Default first fetch address after reset
  localparam logic [63:0] c_reset_pc_default = 64'h8000_0000;

  // True when exactly one of the three selector bits is set
  function automatic logic is_one_hot3(input logic [2:0] sel);
    return (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040088_nextpc.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040088_nextpc
// Description : Combinational next-PC selector. Picks pc+4, the jal target or
//               the jalr target (bit0 cleared) and flags an illegal selection
//               (selector not one-hot, or resulting address not word aligned).
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040088_nextpc
  import ysyx_22040088_ifu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      sel_nextpc,
  input  logic [XLEN-1:0] jal_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic [XLEN-1:0] nextpc,
  output logic            illegal
);

  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_jalr_pc;
  logic [XLEN-1:0] w_sel_pc;

  assign w_seq_pc  = pc + XLEN'(4);
  assign w_jalr_pc = jalr_target & ~(XLEN'(1));

  // Select the candidate and judge its legality; alignment is checked on the
  // selected value so a bad jal/jalr target is caught as well
  always_comb begin
    w_sel_pc = w_seq_pc;
    if (sel_nextpc[c_sel_seq]) begin
      w_sel_pc = w_seq_pc;
    end else if (sel_nextpc[c_sel_jal]) begin
      w_sel_pc = jal_target;
    end else if (sel_nextpc[c_sel_jalr]) begin
      w_sel_pc = w_jalr_pc;
    end
    illegal = !is_one_hot3(sel_nextpc) || (w_sel_pc[1:0] != 2'b00);
  end

  assign nextpc = w_sel_pc;

endmodule
`default_nettype wire

// File: rtl/ysyx_22040088_ifu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040088_ifu
// Description : Instruction fetch unit. Owns the PC, fetches one instruction
//               at a time over a valid/ready memory interface, offers it to
//               decode, and advances the PC once execute reports completion.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040088_ifu
  import ysyx_22040088_ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(c_reset_pc_default)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            ex_done,
  input  logic [2:0]      sel_nextpc,
  input  logic [XLEN-1:0] jal_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic            fetch_err,
  output logic [31:0]     fetch_cnt
);

  ifu_state_t      r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;
  logic [31:0]     r_fetch_cnt;
  logic            r_fetch_err;
  logic            r_req_valid;
  logic            r_inst_valid;

  logic [XLEN-1:0] w_nextpc;
  logic            w_illegal;

  ysyx_22040088_nextpc #(
    .XLEN (XLEN)
  ) u_nextpc (
    .pc          (r_pc),
    .sel_nextpc  (sel_nextpc),
    .jal_target  (jal_target),
    .jalr_target (jalr_target),
    .nextpc      (w_nextpc),
    .illegal     (w_illegal)
  );

  // Fetch FSM; handshake outputs are registered alongside the state so they
  // change only on state transitions
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_inst       <= 32'd0;
      r_fetch_cnt  <= 32'd0;
      r_fetch_err  <= 1'b0;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state     <= S_REQ;
          r_req_valid <= 1'b1;
        end
        S_REQ: begin
          if (imem_req_ready) begin
            r_state     <= S_WAIT_RESP;
            r_req_valid <= 1'b0;
          end
        end
        S_WAIT_RESP: begin
          if (imem_resp_valid) begin
            r_inst       <= imem_resp_data;
            r_state      <= S_ISSUE;
            r_inst_valid <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (inst_ready) begin
            r_fetch_cnt  <= r_fetch_cnt + 32'd1;
            r_state      <= S_WAIT_EX;
            r_inst_valid <= 1'b0;
          end
        end
        S_WAIT_EX: begin
          if (ex_done) begin
            if (w_illegal) begin
              r_state     <= S_ERR;
              r_fetch_err <= 1'b1;
            end else begin
              r_pc        <= w_nextpc;
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end
          end
        end
        S_ERR: begin
          r_state <= S_ERR;
        end
        default: begin
          // Unreachable encodings are treated as a fault
          r_state      <= S_ERR;
          r_fetch_err  <= 1'b1;
          r_req_valid  <= 1'b0;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst           = r_inst;
  assign inst_pc        = r_pc;
  assign fetch_err      = r_fetch_err;
  assign fetch_cnt      = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040088_ifu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22040088_ifu
// Description : Self-checking bench for the instruction fetch unit, with a
//               behavioural next-PC / counter model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040088_ifu;

  localparam int          XLEN   = 64;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic            clk;
  logic            rst_n;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            ex_done;
  logic [2:0]      sel_nextpc;
  logic [XLEN-1:0] jal_target;
  logic [XLEN-1:0] jalr_target;
  logic            fetch_err;
  logic [31:0]     fetch_cnt;

  ysyx_22040088_ifu #(
    .XLEN     (XLEN),
    .RESET_PC (RST_PC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .ex_done         (ex_done),
    .sel_nextpc      (sel_nextpc),
    .jal_target      (jal_target),
    .jalr_target     (jalr_target),
    .fetch_err       (fetch_err),
    .fetch_cnt       (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [63:0] exp_pc;
  logic [31:0] exp_cnt;

  // Observations captured by the stimulus helper
  logic [31:0] obs_inst;
  logic [63:0] obs_pc;
  bit          obs_stable;
  bit          obs_ok;
  int          obs_acc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next PC from the architectural rules; bad=1 means the FSM must trap
  function automatic logic [63:0] ref_next(input logic [63:0] pc, input logic [2:0] sel,
                                           input logic [63:0] jt, input logic [63:0] jrt,
                                           output bit bad);
    logic [63:0] n;
    n = pc;
    if (sel == 3'b001)      n = pc + 64'd4;
    else if (sel == 3'b010) n = jt;
    else if (sel == 3'b100) n = jrt - (jrt % 64'd2);
    bad = ($countones(sel) != 1) || ((n % 64'd4) != 64'd0);
    return n;
  endfunction

  // Account for one issued instruction in the model
  task automatic model_commit(input logic [2:0] sel, input logic [63:0] jt, input logic [63:0] jrt,
                              output bit bad);
    logic [63:0] n;
    n = ref_next(exp_pc, sel, jt, jrt, bad);
    exp_cnt = exp_cnt + 32'd1;
    if (!bad) exp_pc = n;
  endtask

  task automatic count_acc();
    if (imem_req_valid && imem_req_ready) obs_acc++;
  endtask

  // Drives one full instruction starting in REQ; records observations only
  task automatic step_instr(input logic [31:0] data, input logic [2:0] sel,
                            input logic [63:0] jt, input logic [63:0] jrt,
                            input int req_stall, input int resp_dly,
                            input int iss_stall, input int ex_dly);
    logic [63:0] a0;
    obs_ok = 1'b1; obs_stable = 1'b1; obs_acc = 0;
    a0 = imem_req_addr;
    if (!imem_req_valid) obs_ok = 1'b0;
    imem_req_ready = 1'b0;
    for (int i = 0; i < req_stall; i++) begin
      tick();
      if (!imem_req_valid || imem_req_addr !== a0) obs_stable = 1'b0;
    end
    imem_req_ready = 1'b1;
    count_acc(); tick();
    for (int i = 0; i < resp_dly; i++) begin count_acc(); tick(); end
    imem_resp_valid = 1'b1; imem_resp_data = data;
    count_acc(); tick();
    imem_resp_valid = 1'b0; imem_resp_data = $urandom;
    for (int i = 0; i < 8 && !inst_valid; i++) begin count_acc(); tick(); end
    if (!inst_valid) obs_ok = 1'b0;
    obs_inst = inst; obs_pc = inst_pc;
    for (int i = 0; i < iss_stall; i++) begin
      imem_resp_valid = 1'($urandom_range(0, 1)); imem_resp_data = $urandom;
      count_acc(); tick();
      if (inst !== obs_inst || inst_pc !== obs_pc || !inst_valid) obs_stable = 1'b0;
    end
    imem_resp_valid = 1'b0;
    // ex_done coincident with the issue handshake must be ignored
    inst_ready = 1'b1; ex_done = 1'b1; sel_nextpc = 3'b010; jal_target = 64'h1234_5678_9abc_def0;
    count_acc(); tick();
    inst_ready = 1'b0; ex_done = 1'b0;
    for (int i = 0; i < ex_dly; i++) begin count_acc(); tick(); end
    ex_done = 1'b1; sel_nextpc = sel; jal_target = jt; jalr_target = jrt;
    count_acc(); tick();
    ex_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    exp_pc = RST_PC; exp_cnt = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
    inst_ready = 1'b0; ex_done = 1'b0; sel_nextpc = 3'b000; jal_target = '0; jalr_target = '0;
    tick(); tick(); tick();
    checks++;
    if ({imem_req_valid, inst_valid, fetch_err} !== 3'b000 || fetch_cnt !== 32'd0 || inst !== 32'd0)
      $display("FAIL reset_outputs got req=%b iv=%b err=%b cnt=%h inst=%h want all zero",
               imem_req_valid, inst_valid, fetch_err, fetch_cnt, inst);
    else passed++;
    rst_n = 1'b1; exp_pc = RST_PC; exp_cnt = 32'd0;
    checks++;
    if (imem_req_valid !== 1'b0) $display("FAIL boot_cycle got req=%b want 0", imem_req_valid);
    else passed++;
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC)
      $display("FAIL first_req got req=%b addr=%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC);
    else passed++;
  endtask

  task automatic test_sequential();
    bit bad;
    step_instr(32'h0000_0513, 3'b001, '0, '0, 0, 0, 0, 0);
    checks++;
    if (!obs_ok || obs_inst !== 32'h0000_0513 || obs_pc !== exp_pc)
      $display("FAIL seq_issue got ok=%b inst=%h pc=%h want 1/00000513/%h", obs_ok, obs_inst, obs_pc, exp_pc);
    else passed++;
    model_commit(3'b001, '0, '0, bad);
    checks++;
    if (fetch_cnt !== exp_cnt) $display("FAIL seq_cnt got %h want %h", fetch_cnt, exp_cnt);
    else passed++;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004)
      $display("FAIL seq_next got req=%b addr=%h want 1/%h", imem_req_valid, imem_req_addr, 64'h8000_0004);
    else passed++;
  endtask

  task automatic test_backpressure();
    bit bad;
    step_instr(32'h0010_0093, 3'b001, '0, '0, 3, 1, 5, 1);
    model_commit(3'b001, '0, '0, bad);
    checks++;
    if (!obs_ok || !obs_stable) $display("FAIL bp_stable got ok=%b stable=%b want 1/1", obs_ok, obs_stable);
    else passed++;
    checks++;
    if (obs_acc !== 1) $display("FAIL bp_accepts got %0d want 1", obs_acc);
    else passed++;
    checks++;
    if (fetch_cnt !== exp_cnt || obs_inst !== 32'h0010_0093 || imem_req_addr !== exp_pc)
      $display("FAIL bp_result got cnt=%h inst=%h addr=%h want %h/00100093/%h",
               fetch_cnt, obs_inst, imem_req_addr, exp_cnt, exp_pc);
    else passed++;
  endtask

  task automatic test_redirect();
    logic [2:0]  sels [4] = '{3'b010, 3'b100, 3'b010, 3'b001};
    logic [63:0] tgts [4] = '{64'h8000_0100, 64'h8000_0201, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
    bit bad;
    for (int i = 0; i < 4; i++) begin
      step_instr($urandom, sels[i], tgts[i], tgts[i], 0, 0, 1, 0);
      model_commit(sels[i], tgts[i], tgts[i], bad);
      checks++;
      if (!obs_ok || imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc || fetch_err !== 1'b0)
        $display("FAIL redirect_%0d got req=%b addr=%h err=%b want 1/%h/0",
                 i, imem_req_valid, imem_req_addr, fetch_err, exp_pc);
      else passed++;
    end
    do_reset(); tick();
  endtask

  task automatic test_errors();
    logic [2:0]  sels [4] = '{3'b000, 3'b011, 3'b110, 3'b010};
    logic [63:0] tgts [4] = '{64'h8000_0100, 64'h8000_0100, 64'h8000_0100, 64'h8000_0102};
    logic [63:0] pc_before;
    bit bad;
    int reqs;
    for (int i = 0; i < 4; i++) begin
      pc_before = exp_pc;
      step_instr($urandom, sels[i], tgts[i], tgts[i], 0, 0, 0, 1);
      model_commit(sels[i], tgts[i], tgts[i], bad);
      reqs = 0;
      imem_req_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
        if (imem_req_valid || inst_valid) reqs++;
        tick();
      end
      checks++;
      if (!bad || fetch_err !== 1'b1 || reqs != 0 || imem_req_addr !== pc_before)
        $display("FAIL err_%0d got err=%b reqs=%0d addr=%h model_bad=%b want 1/0/%h/1",
                 i, fetch_err, reqs, imem_req_addr, bad, pc_before);
      else passed++;
      do_reset();
      checks++;
      if (fetch_err !== 1'b0 || imem_req_valid !== 1'b0 || imem_req_addr !== RST_PC || fetch_cnt !== 32'd0)
        $display("FAIL err_recover_%0d got err=%b req=%b addr=%h cnt=%h want 0/0/%h/0",
                 i, fetch_err, imem_req_valid, imem_req_addr, fetch_cnt, RST_PC);
      else passed++;
      tick();
    end
  endtask

  task automatic test_mid_reset();
    bit bad;
    step_instr(32'h0000_0013, 3'b010, 64'h8000_0400, '0, 0, 0, 0, 0);
    model_commit(3'b010, 64'h8000_0400, '0, bad);
    imem_req_ready = 1'b1;
    tick();
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 64'h8000_0400)
      $display("FAIL midrst_wait got req=%b addr=%h want 0/%h", imem_req_valid, imem_req_addr, 64'h8000_0400);
    else passed++;
    do_reset();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || inst_valid !== 1'b0 || inst !== 32'd0)
      $display("FAIL midrst_restart got req=%b addr=%h iv=%b inst=%h want 1/%h/0/0",
               imem_req_valid, imem_req_addr, inst_valid, inst, RST_PC);
    else passed++;
    step_instr(32'h0000_0093, 3'b001, '0, '0, 0, 2, 0, 0);
    model_commit(3'b001, '0, '0, bad);
    checks++;
    if (obs_inst !== 32'h0000_0093 || obs_pc !== RST_PC || fetch_cnt !== exp_cnt)
      $display("FAIL midrst_fetch got inst=%h pc=%h cnt=%h want 00000093/%h/%h",
               obs_inst, obs_pc, fetch_cnt, RST_PC, exp_cnt);
    else passed++;
  endtask

  task automatic test_wrap();
    bit bad;
    force dut.r_fetch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_fetch_cnt;
    exp_cnt = 32'hFFFF_FFFF;
    step_instr($urandom, 3'b001, '0, '0, 0, 0, 0, 0);
    model_commit(3'b001, '0, '0, bad);
    checks++;
    if (fetch_cnt !== exp_cnt || exp_cnt !== 32'd0)
      $display("FAIL cnt_wrap got %h want %h", fetch_cnt, 32'd0);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] data;
    logic [2:0]  sel;
    logic [63:0] jt, jrt;
    bit bad;
    int errs;
    errs = 0;
    for (int n = 0; n < 24; n++) begin
      data = $urandom;
      case ($urandom_range(0, 2))
        0:       sel = 3'b001;
        1:       sel = 3'b010;
        default: sel = 3'b100;
      endcase
      jt  = {32'($urandom), 32'($urandom)} & ~64'h3;
      jrt = ({32'($urandom), 32'($urandom)} & ~64'h3) | 64'($urandom_range(0, 1));
      step_instr(data, sel, jt, jrt, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      checks++;
      if (!obs_ok || !obs_stable || obs_acc != 1 || obs_inst !== data || obs_pc !== exp_pc) begin
        $display("FAIL rand_issue_%0d got ok=%b st=%b acc=%0d inst=%h pc=%h want 1/1/1/%h/%h",
                 n, obs_ok, obs_stable, obs_acc, obs_inst, obs_pc, data, exp_pc);
        errs++;
      end else passed++;
      model_commit(sel, jt, jrt, bad);
      checks++;
      if (fetch_cnt !== exp_cnt || imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
        $display("FAIL rand_next_%0d got cnt=%h req=%b addr=%h want %h/1/%h",
                 n, fetch_cnt, imem_req_valid, imem_req_addr, exp_cnt, exp_pc);
        errs++;
      end else passed++;
      if (errs > 4) break;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_errors();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
